// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI burst arbiter/controller slice.
//   state_t      : controller state encoding
//   LEN_W        : width of the per-requester length field (len = bytes - 1)
//   CNT_W        : width of the byte total / byte and prime counters
//   len_to_total : converts a length field into a byte total (len + 1)
package spi_ctrl_pkg;

    localparam int LEN_W = 4;
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_PRIME,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic [CNT_W-1:0] len_to_total(input logic [LEN_W-1:0] len);
        return CNT_W'(len) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-requester arbiter producing a one-hot grant.
// Build option: SPI_ARB_RR_EN
//   defined   : round-robin; the last granted requester loses a tie.
//               The pointer advances whenever 'update' is high.
//   undefined : fixed priority, req[0] wins a tie; no state, no clock.
// Ports:
//   req    in  2  request vector
//   gnt    out 2  one-hot grant (combinational)
//   clk    in  1  clock            (SPI_ARB_RR_EN only)
//   reset  in  1  sync reset       (SPI_ARB_RR_EN only)
//   update in  1  commit the grant (SPI_ARB_RR_EN only)
module spi_rr_arbiter (
    input  logic [1:0] req,
    output logic [1:0] gnt
`ifdef SPI_ARB_RR_EN
    ,
    input  logic       clk,
    input  logic       reset,
    input  logic       update
`endif
);

`ifdef SPI_ARB_RR_EN
    // ptr names the requester with priority; 0 after reset.
    logic ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (update) begin
            // Granting requester 0 hands priority to requester 1 and vice versa.
            ptr <= gnt[0];
        end
    end

    always_comb begin
        gnt = '0;
        if (!ptr) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end
`else
    always_comb begin
        gnt    = '0;
        gnt[0] = req[0];
        gnt[1] = req[1] & ~req[0];
    end
`endif

endmodule

// File: rtl/spi_arb_ctrl.sv
// Arbitrates two byte-burst requesters onto one SPI driver and sequences
// the byte fetches so the driver always has the next byte registered.
// Build option: SPI_ARB_RR_EN selects round-robin arbitration (default is
// fixed priority, requester 0 first).
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   req[1:0]          burst requests, held until granted
//   len0, len1        burst length minus one, sampled at grant
//   din0, din1        show-ahead bytes, consumed on the matching rd bit
//   rd[1:0]           one-cycle pop strobe to the granted requester
//   gnt[1:0]          one-hot grant, LOAD through DONE
//   done[1:0]         one-cycle burst-complete pulse
//   busy              high whenever not IDLE
//   spi_start         one-cycle transfer start
//   spi_end           high while the final byte shifts
//   spi_data          registered byte to the driver
//   spi_rec_sign      driver byte-complete pulse
module spi_arb_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int N_PRIME = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [7:0]       din0,
    input  logic [7:0]       din1,
    output logic [1:0]       rd,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             spi_start,
    output logic             spi_end,
    output logic [7:0]       spi_data,
    input  logic             spi_rec_sign
);

    state_t           state, state_nxt;
    logic [1:0]       gnt_r;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] prime_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic [7:0]       spi_data_r;
    logic             spi_end_r;
    logic             pop;
    logic [1:0]       arb_gnt;
    logic [LEN_W-1:0] len_sel;
    logic [7:0]       din_sel;

`ifdef SPI_ARB_RR_EN
    logic arb_update;
    assign arb_update = (state == ST_IDLE) && (|req) && !reset;

    spi_rr_arbiter u_arb (
        .req    (req),
        .gnt    (arb_gnt),
        .clk    (clk),
        .reset  (reset),
        .update (arb_update)
    );
`else
    spi_rr_arbiter u_arb (
        .req (req),
        .gnt (arb_gnt)
    );
`endif

    assign len_sel = arb_gnt[1] ? len1 : len0;
    assign din_sel = gnt_r[1]   ? din1 : din0;

    // Byte k is the one the driver is shifting when byte_cnt == k; the
    // byte two ahead is fetched on its completion so spi_data always
    // holds the next byte when the driver asks for it.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE:  if (|req) state_nxt = ST_LOAD;
            ST_LOAD: begin
                pop       = 1'b1;
                state_nxt = ST_START;
            end
            ST_START: state_nxt = ST_PRIME;
            ST_PRIME: begin
                if (prime_cnt == CNT_W'(N_PRIME)) begin
                    pop       = (total >= CNT_W'(2));
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (spi_rec_sign) begin
                    pop = (byte_cnt + CNT_W'(2) < total);
                    if (byte_cnt == total - CNT_W'(1)) state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            gnt_r      <= '0;
            total      <= '0;
            prime_cnt  <= '0;
            byte_cnt   <= '0;
            spi_data_r <= '0;
            spi_end_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) spi_data_r <= din_sel;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_r     <= arb_gnt;
                        total     <= len_to_total(len_sel);
                        byte_cnt  <= '0;
                        prime_cnt <= '0;
                    end
                end
                // Single-byte bursts are already on their final byte at START.
                ST_LOAD:  spi_end_r <= (total == CNT_W'(1));
                // prime_cnt equals the number of cycles since spi_start.
                ST_START: prime_cnt <= CNT_W'(1);
                ST_PRIME: prime_cnt <= prime_cnt + CNT_W'(1);
                ST_RUN: begin
                    if (spi_rec_sign) begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        if (total >= CNT_W'(2) && byte_cnt == total - CNT_W'(2))
                            spi_end_r <= 1'b1;
                        if (byte_cnt == total - CNT_W'(1))
                            spi_end_r <= 1'b0;
                    end
                end
                ST_DONE:  gnt_r <= '0;
                default:  ;
            endcase
        end
    end

    // Pulses are gated by reset so an abandoned burst emits nothing more.
    assign rd        = (pop && !reset) ? gnt_r : '0;
    assign done      = ((state == ST_DONE) && !reset) ? gnt_r : '0;
    assign spi_start = (state == ST_START) && !reset;
    assign busy      = (state != ST_IDLE);
    assign gnt       = gnt_r;
    assign spi_end   = spi_end_r;
    assign spi_data  = spi_data_r;

endmodule

// File: tb/tb_spi_arb_ctrl.sv
module tb_spi_arb_ctrl;

    localparam int NP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0, len1;
    logic [7:0] din0, din1;
    logic [1:0] rd, gnt, done;
    logic       busy, spi_start, spi_end;
    logic [7:0] spi_data;
    logic       spi_rec_sign;

    always #5 clk = ~clk;

    spi_arb_ctrl #(.N_PRIME(NP)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .len0         (len0),
        .len1         (len1),
        .din0         (din0),
        .din1         (din1),
        .rd           (rd),
        .gnt          (gnt),
        .done         (done),
        .busy         (busy),
        .spi_start    (spi_start),
        .spi_end      (spi_end),
        .spi_data     (spi_data),
        .spi_rec_sign (spi_rec_sign)
    );

    int compared = 0;
    int mismatched = 0;

    logic [7:0] src0[$];
    logic [7:0] src1[$];
    logic [7:0] exp_q[$];
    int rd_cnt0 = 0;
    int rd_cnt1 = 0;

    logic [1:0] s_rd, s_gnt, s_done;
    logic       s_busy, s_start, s_end;
    logic [7:0] s_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic refresh_din();
        din0 = (src0.size() > 0) ? src0[0] : 8'h00;
        din1 = (src1.size() > 0) ? src1[0] : 8'h00;
    endtask

    // Sample outputs mid-cycle, then retire popped bytes after the edge.
    task automatic cycle();
        @(negedge clk);
        s_rd = rd; s_gnt = gnt; s_done = done; s_busy = busy;
        s_start = spi_start; s_end = spi_end; s_data = spi_data;
        if (s_rd[0]) rd_cnt0++;
        if (s_rd[1]) rd_cnt1++;
        @(posedge clk);
        #1;
        if (s_rd[0] && src0.size() > 0) src0.delete(0);
        if (s_rd[1] && src1.size() > 0) src1.delete(0);
        refresh_din();
    endtask

    task automatic load_bytes(input int who, input int n, input logic [7:0] first,
                              input logic [7:0] stepv, input bit push_exp);
        logic [7:0] b;
        b = first;
        for (int i = 0; i < n; i++) begin
            if (who == 0) src0.push_back(b); else src1.push_back(b);
            if (push_exp) exp_q.push_back(b);
            b = b + stepv;
        end
        refresh_din();
    endtask

    function automatic logic [7:0] next_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    task automatic run_burst(input string nm, input logic [1:0] exp_g, input int total,
                             input bit chk_offset, input logic [1:0] req_after);
        int  n;
        bit  seen;
        int  r0, r1;
        r0 = rd_cnt0; r1 = rd_cnt1;
        n = 0; seen = 1'b0;
        while (!seen && n < 12) begin
            cycle();
            n++;
            seen = s_start;
        end
        chk({nm, " start_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        if (chk_offset) chk({nm, " start_offset"}, 32'(n), 32'd3);
        chk({nm, " gnt_at_start"}, 32'(s_gnt), 32'(exp_g));
        chk({nm, " end_at_start"}, 32'(s_end), 32'(total == 1));
        chk({nm, " byte0"}, 32'(s_data), 32'(next_exp()));
        req = req_after;
        repeat (NP + 2) cycle();
        chk({nm, " rd_after_prime"}, 32'(exp_g[0] ? rd_cnt0 - r0 : rd_cnt1 - r1),
            32'(total >= 2 ? 2 : 1));
        for (int k = 0; k < total; k++) begin
            spi_rec_sign = 1'b1;
            cycle();
            spi_rec_sign = 1'b0;
            chk({nm, " end_at_rec"}, 32'(s_end), 32'(k == total - 1));
            chk({nm, " rd_at_rec"}, 32'(s_rd), 32'((k + 2 < total) ? exp_g : 2'b00));
            if (k + 1 < total) chk({nm, " next_byte"}, 32'(s_data), 32'(next_exp()));
            if (k < total - 1) begin
                cycle();
                chk({nm, " end_gap"}, 32'(s_end), 32'(k == total - 2));
                chk({nm, " done_gap"}, 32'(s_done), 32'd0);
            end
        end
        cycle();
        chk({nm, " done"}, 32'(s_done), 32'(exp_g));
        chk({nm, " gnt_in_done"}, 32'(s_gnt), 32'(exp_g));
        chk({nm, " end_in_done"}, 32'(s_end), 32'd0);
        cycle();
        chk({nm, " idle_busy"}, 32'(s_busy), 32'd0);
        chk({nm, " idle_gnt"}, 32'(s_gnt), 32'd0);
        chk({nm, " idle_done"}, 32'(s_done), 32'd0);
        chk({nm, " rd_total0"}, 32'(rd_cnt0 - r0), 32'(exp_g[0] ? total : 0));
        chk({nm, " rd_total1"}, 32'(rd_cnt1 - r1), 32'(exp_g[1] ? total : 0));
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " rd"}, 32'(s_rd), 32'd0);
        chk({nm, " gnt"}, 32'(s_gnt), 32'd0);
        chk({nm, " done"}, 32'(s_done), 32'd0);
        chk({nm, " busy"}, 32'(s_busy), 32'd0);
        chk({nm, " start"}, 32'(s_start), 32'd0);
        chk({nm, " end"}, 32'(s_end), 32'd0);
        chk({nm, " data"}, 32'(s_data), 32'd0);
    endtask

    initial begin
        int  n;
        bit  seen;

        reset = 1'b1; req = 2'b00; len0 = '0; len1 = '0;
        spi_rec_sign = 1'b0;
        refresh_din();
        cycle(); cycle();
        reset = 1'b0;
        cycle();
        chk_quiet("reset");

        // rec_sign while idle must be ignored
        spi_rec_sign = 1'b1;
        cycle();
        spi_rec_sign = 1'b0;
        chk("idle_rec rd", 32'(s_rd), 32'd0);
        chk("idle_rec busy", 32'(s_busy), 32'd0);
        cycle();
        chk("idle_rec busy_after", 32'(s_busy), 32'd0);

        // single-byte burst
        len0 = 4'd0;
        load_bytes(0, 1, 8'hA5, 8'h00, 1'b1);
        req = 2'b01;
        run_burst("s1", 2'b01, 1, 1'b1, 2'b00);

        // three-byte burst from requester 1
        len1 = 4'd2;
        load_bytes(1, 3, 8'h11, 8'h11, 1'b1);
        req = 2'b10;
        run_burst("s3", 2'b10, 3, 1'b1, 2'b00);

        // both requesting for two bursts
        len0 = 4'd1; len1 = 4'd1;
`ifdef SPI_ARB_RR_EN
        load_bytes(0, 2, 8'h40, 8'h01, 1'b1);
        load_bytes(1, 2, 8'h80, 8'h01, 1'b1);
        req = 2'b11;
        run_burst("tie_a", 2'b01, 2, 1'b1, 2'b11);
        run_burst("tie_b", 2'b10, 2, 1'b0, 2'b00);
`else
        load_bytes(0, 4, 8'h40, 8'h01, 1'b1);
        load_bytes(1, 2, 8'h80, 8'h01, 1'b0);
        req = 2'b11;
        run_burst("tie_a", 2'b01, 2, 1'b1, 2'b11);
        run_burst("tie_b", 2'b01, 2, 1'b0, 2'b00);
`endif
        src1.delete();
        refresh_din();

        // maximum length
        len0 = 4'd15;
        load_bytes(0, 16, 8'h01, 8'h07, 1'b1);
        req = 2'b01;
        run_burst("max", 2'b01, 16, 1'b1, 2'b00);

        // reset during RUN of a 4-byte burst
        len0 = 4'd3;
        load_bytes(0, 4, 8'hC0, 8'h01, 1'b0);
        req = 2'b01;
        n = 0; seen = 1'b0;
        while (!seen && n < 12) begin
            cycle();
            n++;
            seen = s_start;
        end
        chk("midrst start_seen", 32'(seen), 32'd1);
        req = 2'b00;
        repeat (NP + 2) cycle();
        spi_rec_sign = 1'b1;
        cycle();
        spi_rec_sign = 1'b0;
        chk("midrst busy_run", 32'(s_busy), 32'd1);
        reset = 1'b1;
        cycle();
        chk("midrst rd_in_reset", 32'(s_rd), 32'd0);
        chk("midrst done_in_reset", 32'(s_done), 32'd0);
        reset = 1'b0;
        cycle();
        chk_quiet("midrst after");
        cycle();
        chk("midrst stays_idle", 32'(s_busy), 32'd0);
        src0.delete();
        exp_q.delete();
        refresh_din();

        len0 = 4'd1;
        load_bytes(0, 2, 8'h5A, 8'h21, 1'b1);
        req = 2'b01;
        run_burst("post_rst", 2'b01, 2, 1'b1, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
